// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data memory access controller.
// Registers a load/store request toward data memory, stalls the pipeline
// until the memory acknowledges, and registers the load result for MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after
// ACK_TIMEOUT unacknowledged BUSY cycles and raise the sticky error_o flag.
module mem_access_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] writeData_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        stall_o,
    output logic [31:0] readData_o,
    output logic        readValid_o,
    output logic        error_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   access_req;
    logic   timeout_hit;

    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: ACK_TIMEOUT must be in 1..255");
    end

    // A new access is only taken while the pipeline runs.
    assign access_req = start_i & (MemRead_i | MemWrite_i);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Abandon the access on the last permitted unacknowledged BUSY cycle.
    assign timeout_hit = (state_q == BUSY) && !mem_ack_i &&
                         (wait_cnt == 8'(ACK_TIMEOUT - 1));

    // Count unacknowledged BUSY cycles; restart from zero for every access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= 8'd0;
        end else if (state_q == BUSY && !mem_ack_i && !timeout_hit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_o <= 1'b0;
        end else if (timeout_hit) begin
            error_o <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error_o     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_req) begin
                    state_d = BUSY;
                    stall_o = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory request registers and load-result capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_data_o  <= 32'h0;
            readData_o  <= 32'h0;
            readValid_o <= 1'b0;
        end else begin
            readValid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_req) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= MemWrite_i;
                        mem_addr_o <= addr_i;
                        mem_data_o <= writeData_i;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            readData_o  <= mem_data_i;
                            readValid_o <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: maximum cycles BUSY waits for mem_ack_i (range 1..255); used only with MEM_TIMEOUT_EN.
REQ-002 clk_i  input  1  single clock; all state updates on posedge clk_i.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  pipeline run enable; new accesses accepted only while high.
REQ-005 MemRead_i  input  1  MEM-stage load request, from the EX/MEM pipeline register.
REQ-006 MemWrite_i  input  1  MEM-stage store request, from the EX/MEM pipeline register.
REQ-007 addr_i  input  32  access address (EX/MEM ALU result).
REQ-008 writeData_i  input  32  store data (EX/MEM write data).
REQ-009 mem_ack_i  input  1  data memory completion strobe.
REQ-010 mem_data_i  input  32  data memory read data, valid when mem_ack_i=1.
REQ-011 mem_req_o  output  1  registered request to data memory.
REQ-012 mem_we_o  output  1  registered write enable: 1=store, 0=load.
REQ-013 mem_addr_o  output  32  registered address to data memory.
REQ-014 mem_data_o  output  32  registered store data to data memory.
REQ-015 stall_o  output  1  combinational hold for PC, IF/ID, ID/EX and EX/MEM registers.
REQ-016 readData_o  output  32  registered load result for the MEM/WB register.
REQ-017 readValid_o  output  1  one-cycle strobe: readData_o holds a fresh load result.
REQ-018 error_o  output  1  sticky timeout flag; present only with MEM_TIMEOUT_EN (otherwise tied 0).

Function
REQ-019 FSM states IDLE, BUSY, DONE; encoding is implementation-chosen.
REQ-020 IDLE->BUSY when start_i=1 and (MemRead_i|MemWrite_i)=1; same edge latches addr_i into mem_addr_o, writeData_i into mem_data_o, MemWrite_i into mem_we_o, and sets mem_req_o=1.
REQ-021 MemRead_i and MemWrite_i both 1: treated as store (mem_we_o=1).
REQ-022 stall_o=1 in IDLE when the REQ-020 condition holds, and in all of BUSY; stall_o=0 in DONE and otherwise.
REQ-023 BUSY->DONE on an edge where mem_ack_i=1; same edge clears mem_req_o; load additionally latches mem_data_i into readData_o.
REQ-024 mem_req_o, mem_we_o, mem_addr_o and mem_data_o remain stable throughout BUSY.
REQ-025 DONE->IDLE unconditionally after one cycle; no new access starts from DONE, even with MemRead_i/MemWrite_i still asserted.
REQ-026 readValid_o=1 exactly during the DONE cycle of a load; 0 for stores and in all other states.
REQ-027 mem_ack_i ignored in IDLE and DONE.
REQ-028 start_i low during BUSY does not abort; the access completes normally.
REQ-029 Minimum latency: request seen in IDLE at cycle 0 -> mem_req_o high cycle 1 -> ack at cycle 1 -> DONE cycle 2 -> stall_o low at cycle 2; total stall 2 cycles.
REQ-030 readData_o holds its value until the next completed load.

Reset
REQ-031 rst_i=1 at an edge forces IDLE; mem_req_o, mem_we_o, readValid_o, error_o to 0; mem_addr_o, mem_data_o, readData_o to 32'h0; wait counter to 0.
REQ-032 Reset during BUSY drops mem_req_o the following cycle; an ack arriving afterwards is ignored.
REQ-033 rst_i takes priority over every other input.

Configuration
REQ-034 Macro MEM_TIMEOUT_EN defined: a counter increments each BUSY cycle without ack; on reaching ACK_TIMEOUT, FSM goes to IDLE, mem_req_o clears, error_o sets and stays 1 until reset, and readData_o is left unchanged.
REQ-035 MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; error_o constant 0.

Verification
REQ-036 Load with ack after 3 BUSY cycles, addr_i=32'h10, mem_data_i=32'hDEADBEEF -> stall_o high 4 cycles; readData_o=32'hDEADBEEF with a 1-cycle readValid_o pulse.
REQ-037 Store with MemRead_i=MemWrite_i=1, addr_i=32'h20, writeData_i=32'h5A5A5A5A -> mem_we_o=1, mem_data_o=32'h5A5A5A5A stable until ack; readValid_o stays 0.
REQ-038 Back-to-back loads: MemRead_i held high through DONE -> exactly one request per instruction; IDLE cycle precedes the second mem_req_o.
REQ-039 rst_i pulsed in BUSY, ack 2 cycles later -> all outputs reset values; no readValid_o pulse.
REQ-040 MEM_TIMEOUT_EN, ACK_TIMEOUT=4, no ack -> after 4 BUSY cycles mem_req_o=0, stall_o=0, error_o=1 held until rst_i.
REQ-041 start_i=0 with MemRead_i=1 in IDLE -> no request; stall_o=0.
